// File: rtl/pauli_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pauli_frame_pkg                                           |
// | Purpose  : Shared axis encodings, collector states and widths for    |
// |            the Pauli frame tracker.                                  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package pauli_frame_pkg;

    localparam int NUM_QUBITS = 5;
    localparam int CNT_W      = 8;

    localparam logic [1:0] AX_NONE = 2'b00;
    localparam logic [1:0] AX_X    = 2'b01;
    localparam logic [1:0] AX_Y    = 2'b10;
    localparam logic [1:0] AX_Z    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_X = 2'd1,
        GOT_Y = 2'd2
    } coll_state_t;

endpackage
`default_nettype wire

// File: rtl/pauli_round_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pauli_round_collector                                     |
// | Purpose  : Gathers X, Y, Z syndrome corrections into one round and   |
// |            flags axis-sequence violations.                           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pauli_round_collector
    import pauli_frame_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            axis_in,
    input  logic [NUM_QUBITS-1:0] corr_in,
    output logic                  done,
    output logic [NUM_QUBITS-1:0] rx,
    output logic [NUM_QUBITS-1:0] rz,
    output logic                  seq_err
);

    coll_state_t           r_state;
    logic [NUM_QUBITS-1:0] r_cx;
    logic [NUM_QUBITS-1:0] r_cy;
    logic                  r_seq_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cx      <= '0;
            r_cy      <= '0;
            r_seq_err <= 1'b0;
        end else begin
            r_seq_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (axis_in == AX_X) begin
                        r_cx    <= corr_in;
                        r_state <= GOT_X;
                    end else if (axis_in != AX_NONE) begin
                        r_seq_err <= 1'b1;
                    end
                end
                GOT_X: begin
                    if (axis_in == AX_Y) begin
                        r_cy    <= corr_in;
                        r_state <= GOT_Y;
                    end else if (axis_in == AX_X) begin
                        // A repeated X restarts the round with the newer data
                        r_seq_err <= 1'b1;
                        r_cx      <= corr_in;
                    end else begin
                        r_seq_err <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                GOT_Y: begin
                    if (axis_in == AX_Z) begin
                        r_state <= IDLE;
                    end else if (axis_in == AX_X) begin
                        r_seq_err <= 1'b1;
                        r_cx      <= corr_in;
                        r_state   <= GOT_X;
                    end else begin
                        r_seq_err <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Y acts on both components, so it folds into X and Z alike
    assign done    = (r_state == GOT_Y) && (axis_in == AX_Z);
    assign rx      = r_cx ^ r_cy;
    assign rz      = corr_in ^ r_cy;
    assign seq_err = r_seq_err;

endmodule
`default_nettype wire

// File: rtl/pauli_frame_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pauli_frame_tracker                                       |
// | Purpose  : Accumulates per-round Pauli corrections into a frame and  |
// |            buffers each round result behind a valid/ready handshake. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pauli_frame_tracker
    import pauli_frame_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            axis_in,
    input  logic [NUM_QUBITS-1:0] corr_in,
    input  logic                  frame_clr,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [NUM_QUBITS-1:0] out_x,
    output logic [NUM_QUBITS-1:0] out_z,
    output logic [NUM_QUBITS-1:0] frame_x,
    output logic [NUM_QUBITS-1:0] frame_z,
    output logic [CNT_W-1:0]      round_cnt,
    output logic                  seq_err,
    output logic                  overflow
);

    logic                  w_done;
    logic [NUM_QUBITS-1:0] w_rx;
    logic [NUM_QUBITS-1:0] w_rz;
    logic [NUM_QUBITS-1:0] w_fx_base;
    logic [NUM_QUBITS-1:0] w_fz_base;
    logic [CNT_W-1:0]      w_cnt_base;
    logic                  w_ovf_base;

    logic                  r_valid;
    logic [NUM_QUBITS-1:0] r_out_x;
    logic [NUM_QUBITS-1:0] r_out_z;
    logic [NUM_QUBITS-1:0] r_frame_x;
    logic [NUM_QUBITS-1:0] r_frame_z;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ovf;

    pauli_round_collector u_collector (
        .CLK     (CLK),
        .RST     (RST),
        .axis_in (axis_in),
        .corr_in (corr_in),
        .done    (w_done),
        .rx      (w_rx),
        .rz      (w_rz),
        .seq_err (seq_err)
    );

    // Clear is applied before a coincident completion folds in
    assign w_fx_base  = frame_clr ? '0 : r_frame_x;
    assign w_fz_base  = frame_clr ? '0 : r_frame_z;
    assign w_cnt_base = frame_clr ? '0 : r_cnt;
    assign w_ovf_base = frame_clr ? 1'b0 : r_ovf;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid   <= 1'b0;
            r_out_x   <= '0;
            r_out_z   <= '0;
            r_frame_x <= '0;
            r_frame_z <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_done) begin
                r_out_x <= w_rx;
                r_out_z <= w_rz;
                r_valid <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            r_frame_x <= w_done ? (w_fx_base ^ w_rx) : w_fx_base;
            r_frame_z <= w_done ? (w_fz_base ^ w_rz) : w_fz_base;
            r_cnt     <= w_cnt_base + {{(CNT_W-1){1'b0}}, w_done};
            r_ovf     <= w_ovf_base | (w_done && r_valid && !out_ready);
        end
    end

    assign out_valid = r_valid;
    assign out_x     = r_out_x;
    assign out_z     = r_out_z;
    assign frame_x   = r_frame_x;
    assign frame_z   = r_frame_z;
    assign round_cnt = r_cnt;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: doc/pauli_frame_tracker.md
PAULI_FRAME_TRACKER -- requirements
Module: pauli_frame_tracker

Interface
REQ-001 CLK  input  1  clock; all state updates on rising edge.
REQ-002 RST  input  1  reset, synchronous, active-high.
REQ-003 axis_in  input  2  axis tag from syndrome LUT: 00 none, 01 X, 10 Y, 11 Z.
REQ-004 corr_in  input  5  one-hot or zero per-qubit correction for axis_in; bit 4 = qubit 0.
REQ-005 frame_clr  input  1  clear the accumulated frame and round counter.
REQ-006 out_ready  input  1  downstream accepts the round result.
REQ-007 out_valid  output  1  round result is present.
REQ-008 out_x, out_z  output  5 each  per-qubit X/Z components of the last completed round.
REQ-009 frame_x, frame_z  output  5 each  accumulated Pauli frame.
REQ-010 round_cnt  output  8  completed rounds since reset or clear.
REQ-011 seq_err  output  1  one-cycle pulse on an axis-sequence violation.
REQ-012 overflow  output  1  sticky flag: an unaccepted result was overwritten.

Function
REQ-013 Inputs SHALL be sampled directly, unregistered; the upstream LUT emits axis 00 once after reset, then 01,10,11 repeating.
REQ-014 Collector FSM states SHALL be IDLE, GOT_X and GOT_Y.
REQ-015 IDLE: axis 00 holds; 01 latches cx=corr_in and goes to GOT_X; 10 or 11 pulses seq_err and holds.
REQ-016 GOT_X: 10 latches cy and goes to GOT_Y; 01 pulses seq_err, latches new cx and holds; 00 or 11 pulses seq_err and goes to IDLE.
REQ-017 GOT_Y: 11 completes the round and goes to IDLE; 01 pulses seq_err, latches cx and goes to GOT_X; 00 or 10 pulses seq_err and goes to IDLE.
REQ-018 Round result on completion SHALL be: rx = cx XOR cy; rz = corr_in XOR cy. Y contributes both X and Z.
REQ-019 At the edge after completion, the following updates SHALL occur together:
  - out_x/out_z = rx/rz
  - out_valid = 1
  - frame_x ^= rx; frame_z ^= rz
  - round_cnt increments, wrapping 255 -> 0.
REQ-020 Latency SHALL be 1 cycle from sampling axis 11 to visible outputs; sustained throughput is one round per 3 cycles.
REQ-021 Transfer SHALL occur when out_valid and out_ready are both high at an edge; out_valid then clears unless a completion occurs on the same edge.
REQ-022 Completion while out_valid=1 and out_ready=0 SHALL overwrite out_x/out_z, keep out_valid=1 and set overflow.
REQ-023 Completion with simultaneous transfer SHALL load the new result, keep out_valid=1 and leave overflow unchanged.
REQ-024 out_x/out_z SHALL hold stable while out_valid=1 and no completion occurs.
REQ-025 frame_clr SHALL zero frame_x, frame_z, round_cnt and overflow at the next edge; the FSM, out_valid and out data are unaffected.
REQ-026 frame_clr coincident with completion SHALL apply clear first: frame = rx/rz and round_cnt = 1.
REQ-027 A partial round discarded by a violation SHALL never affect the frame, the outputs or round_cnt.

Reset
REQ-028 RST SHALL zero all outputs, cx and cy, and force the FSM to IDLE.
REQ-029 RST SHALL take priority over frame_clr and over any completion in the same cycle.
REQ-030 RST mid-round SHALL discard the partial round.

Structure
REQ-031 Package pauli_frame_pkg SHALL hold:
  - axis encodings AX_NONE/AX_X/AX_Y/AX_Z
  - the collector state enum
  - NUM_QUBITS=5, CNT_W=8.
REQ-032 Sub-module pauli_round_collector SHALL contain the FSM, cx/cy and the completion/seq_err generation; the top level SHALL contain the frame, counter, output buffer and handshake.

Verification
REQ-033 Reset, then axis 00, then 01/10000, 10/00000, 11/00000 -> out_valid=1, out_x=10000, out_z=00000, frame_x=10000, round_cnt=1.
REQ-034 Round with X=00000, Y=00100, Z=00000 -> out_x=00100, out_z=00100; frame updated by XOR.
REQ-035 Two consecutive rounds, each X=00001, with out_ready=1 -> frame_x=00000 and round_cnt=2; out_valid pulses per round.
REQ-036 out_ready=0 across two rounds (first X=10000, then Z=01000) -> overflow=1, out_x=00000, out_z=01000; then out_ready=1 -> out_valid=0 next cycle.
REQ-037 Sequence 01 then 11 -> seq_err high exactly 1 cycle; no out_valid; round_cnt unchanged; next 01/10/11 completes normally.
REQ-038 frame_clr asserted on the completion cycle of round X=00010 with frame_x=11000 beforehand -> frame_x=00010, round_cnt=1, overflow=0.
